// File: rtl/jk_link_pkg.sv
// Shared definitions for the remote-player serial link: framing constants,
// deframer state encoding and the decoded position record.
package jk_link_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CHK_SEED  = 8'h5A;
    localparam int         FRAME_LEN = 5;

    // Payload bytes between SYNC and CHK.
    localparam int PAYLOAD_LEN = FRAME_LEN - 2;

    typedef enum logic [2:0] {
        HUNT,
        GET_B1,
        GET_B2,
        GET_B3,
        GET_CHK
    } deframer_state_e;

    typedef struct packed {
        logic [1:0]  level;
        logic [10:0] y;
        logic [10:0] x;
    } remote_state_t;

    // Checksum over the three payload bytes, used by both ends of the link.
    function automatic logic [7:0] frame_checksum(input logic [7:0] b1,
                                                  input logic [7:0] b2,
                                                  input logic [7:0] b3);
        return b1 ^ b2 ^ b3 ^ CHK_SEED;
    endfunction

endpackage

// File: rtl/remote_state_deframer_sat_timer.sv
// Saturating cycle counter: counts up every cycle, clears on clr, and
// flags expired while the count sits at LIMIT.
module sat_timer #(
    parameter int LIMIT = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic expired
);

    localparam int             W       = $clog2(LIMIT + 1);
    localparam logic [W-1:0]   LIMIT_W = W'(LIMIT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins, otherwise increment until pinned at LIMIT.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (count_q != LIMIT_W) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LIMIT_W);

endmodule

// File: rtl/remote_state_deframer.sv
// Receives 5-byte position frames from the UART, validates the checksum and
// publishes the remote player's X/Y/level, plus link health indicators.
module remote_state_deframer #(
    parameter int GAP_CYCLES   = 100000,
    parameter int LINK_TIMEOUT = 10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [11:0] x_value_rm,
    output logic [11:0] y_value_rm,
    output logic [1:0]  level_rm,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        link_up,
    output logic [7:0]  err_count
);

    import jk_link_pkg::*;

    deframer_state_e              state_q, state_d;
    logic [PAYLOAD_LEN-1:0][7:0]  shadow_q, shadow_d;
    remote_state_t                rm_q, rm_d;
    logic                         frame_ok_q, frame_ok_d;
    logic                         frame_err_q, frame_err_d;
    logic                         link_up_q, link_up_d;
    logic [7:0]                   err_count_q, err_count_d;

    logic commit;
    logic gap_clr;
    logic gap_expired;
    logic link_expired;

    // The gap timer only runs while a frame is in progress and between bytes.
    assign gap_clr = rx_valid || (state_q == HUNT);

    sat_timer #(
        .LIMIT (GAP_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (gap_clr),
        .expired (gap_expired)
    );

    // The limit is one short of LINK_TIMEOUT so that the registered link_up
    // falls on exactly the LINK_TIMEOUT-th cycle after frame_ok.
    sat_timer #(
        .LIMIT (LINK_TIMEOUT - 1)
    ) u_link_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (commit),
        .expired (link_expired)
    );

    // Frame FSM, shadow capture, commit and error/link bookkeeping.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        rm_d        = rm_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        commit      = 1'b0;

        case (state_q)
            HUNT: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = GET_B1;
                end
            end
            GET_B1: begin
                if (rx_valid) begin
                    shadow_d[0] = rx_data;
                    state_d     = GET_B2;
                end
            end
            GET_B2: begin
                if (rx_valid) begin
                    shadow_d[1] = rx_data;
                    state_d     = GET_B3;
                end
            end
            GET_B3: begin
                if (rx_valid) begin
                    shadow_d[2] = rx_data;
                    state_d     = GET_CHK;
                end
            end
            GET_CHK: begin
                if (rx_valid) begin
                    state_d = HUNT;
                    if (rx_data == frame_checksum(shadow_q[0], shadow_q[1], shadow_q[2])) begin
                        commit = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        // A byte arriving on the expiry cycle keeps the frame alive.
        if ((state_q != HUNT) && !rx_valid && gap_expired) begin
            state_d     = HUNT;
            frame_err_d = 1'b1;
        end

        if (commit) begin
            rm_d.x     = {shadow_q[1][2:0], shadow_q[0]};
            rm_d.y     = {shadow_q[2][5:0], shadow_q[1][7:3]};
            rm_d.level = shadow_q[2][7:6];
        end
        frame_ok_d = commit;

        err_count_d = err_count_q;
        if (frame_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end

        // A fresh frame beats a simultaneous timeout.
        link_up_d = commit || (link_up_q && !link_expired);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            shadow_q    <= '0;
            rm_q        <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            link_up_q   <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            rm_q        <= rm_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            link_up_q   <= link_up_d;
            err_count_q <= err_count_d;
        end
    end

    assign x_value_rm = {1'b0, rm_q.x};
    assign y_value_rm = {1'b0, rm_q.y};
    assign level_rm   = rm_q.level;
    assign frame_ok   = frame_ok_q;
    assign frame_err  = frame_err_q;
    assign link_up    = link_up_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_remote_state_deframer.sv
// Scoreboarded bench for remote_state_deframer: directed scenarios followed
// by randomized byte streams, checked against a byte-level frame model.
module tb_remote_state_deframer;

    localparam int GAP  = 100;
    localparam int LINK = 1000;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] x_value_rm;
    logic [11:0] y_value_rm;
    logic [1:0]  level_rm;
    logic        frame_ok;
    logic        frame_err;
    logic        link_up;
    logic [7:0]  err_count;

    remote_state_deframer #(
        .GAP_CYCLES   (GAP),
        .LINK_TIMEOUT (LINK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .x_value_rm (x_value_rm),
        .y_value_rm (y_value_rm),
        .level_rm   (level_rm),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .link_up    (link_up),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit          is_err;
        int          at;
        logic [11:0] x;
        logic [11:0] y;
        logic [1:0]  lvl;
        logic [7:0]  errc;
    } ev_t;

    ev_t exp_q[$];

    // Reference model: position within the frame and the bytes seen so far.
    int          m_pos = 0;
    logic [7:0]  m_pb [3];
    int          m_last = 0;
    logic [11:0] m_x = 0;
    logic [11:0] m_y = 0;
    logic [1:0]  m_lvl = 0;
    int          m_errc = 0;
    bit          m_ok_valid = 0;
    int          m_ok_at = 0;
    bit          m_prev_valid = 0;
    int          m_prev_at = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_event(input bit is_err, input int at);
        ev_t e;
        e.is_err = is_err;
        e.at     = at;
        e.x      = m_x;
        e.y      = m_y;
        e.lvl    = m_lvl;
        e.errc   = 8'(m_errc);
        exp_q.push_back(e);
    endtask

    task automatic model_error(input int at);
        m_pos = 0;
        if (m_errc < 255) m_errc++;
        push_event(1'b1, at);
    endtask

    task automatic model_byte(input logic [7:0] b, input int at);
        logic [7:0] chk;
        m_last = at;
        if (m_pos == 0) begin
            if (b == 8'hA5) m_pos = 1;
        end else if (m_pos < 4) begin
            m_pb[m_pos-1] = b;
            m_pos++;
        end else begin
            chk = m_pb[0] ^ m_pb[1] ^ m_pb[2] ^ 8'h5A;
            if (b == chk) begin
                m_pos = 0;
                m_x   = {1'b0, m_pb[1][2:0], m_pb[0]};
                m_y   = {1'b0, m_pb[2][5:0], m_pb[1][7:3]};
                m_lvl = m_pb[2][7:6];
                m_prev_valid = m_ok_valid;
                m_prev_at    = m_ok_at;
                m_ok_valid   = 1'b1;
                m_ok_at      = at + 1;
                push_event(1'b0, at + 1);
            end else begin
                model_error(at + 1);
            end
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        model_byte(b, cyc);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Idle for n cycles; a frame left open longer than GAP idle cycles aborts.
    task automatic idle(input int n);
        if ((m_pos != 0) && (cyc + n > m_last + GAP + 1)) begin
            model_error(m_last + GAP + 2);
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        m_pos = 0;
        m_x = 0;
        m_y = 0;
        m_lvl = 0;
        m_errc = 0;
        m_ok_valid = 0;
        m_prev_valid = 0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [39:0] encode(input logic [10:0] x, input logic [10:0] y, input logic [1:0] lvl);
        logic [7:0] b1, b2, b3;
        b1 = x[7:0];
        b2 = {y[4:0], x[10:8]};
        b3 = {lvl, y[10:5]};
        return {8'hA5, b1, b2, b3, b1 ^ b2 ^ b3 ^ 8'h5A};
    endfunction

    task automatic send_bytes(input logic [39:0] f, input int nbytes, input int gap);
        for (int i = 0; i < nbytes; i++) begin
            if (i > 0) idle(gap);
            strobe(f[39 - 8*i -: 8]);
        end
    endtask

    function automatic int rand_gap();
        int r;
        r = $urandom_range(0, 31);
        if (r == 0) return GAP;
        if (r == 1) return GAP + 1;
        if (r == 2) return GAP - 1;
        if (r < 14) return 0;
        return $urandom_range(1, 12);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_x"}, 32'(x_value_rm), 32'(m_x));
        check({tag, "_y"}, 32'(y_value_rm), 32'(m_y));
        check({tag, "_level"}, 32'(level_rm), 32'(m_lvl));
        check({tag, "_err_count"}, 32'(err_count), 32'(m_errc));
    endtask

    // Monitor: pop the scoreboard on every pulse and track link_up each cycle.
    always @(negedge clk) begin
        if (rst) begin
            if ((exp_q.size() > 0) && (exp_q[0].at < cyc)) begin
                ev_t lost;
                lost = exp_q.pop_front();
                check("missing_event_cycle", 32'(cyc), 32'(lost.at));
            end
            if (frame_ok || frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event_ok_err", {30'd0, frame_ok, frame_err}, 32'd0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    $display("cycle %0d: %s x=%03h y=%03h lvl=%0d errc=%0d",
                             cyc, frame_ok ? "frame_ok " : "frame_err",
                             x_value_rm, y_value_rm, level_rm, err_count);
                    check("event_cycle", 32'(cyc), 32'(e.at));
                    check("event_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
                    check("event_kind_ok", {31'd0, frame_ok}, {31'd0, !e.is_err});
                    check("event_x", 32'(x_value_rm), 32'(e.x));
                    check("event_y", 32'(y_value_rm), 32'(e.y));
                    check("event_level", 32'(level_rm), 32'(e.lvl));
                    check("event_err_count", 32'(err_count), 32'(e.errc));
                end
            end
            check("link_up", {31'd0, link_up},
                  {31'd0, (m_ok_valid && cyc >= m_ok_at && cyc < m_ok_at + LINK) ||
                          (m_prev_valid && cyc >= m_prev_at && cyc < m_prev_at + LINK)});
        end
    end

    initial begin
        int f_at;
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_x", 32'(x_value_rm), 32'd0);
        check("reset_y", 32'(y_value_rm), 32'd0);
        check("reset_level", 32'(level_rm), 32'd0);
        check("reset_frame_ok", {31'd0, frame_ok}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_link_up", {31'd0, link_up}, 32'd0);
        check("reset_err_count", 32'(err_count), 32'd0);
        rst = 1'b1;
        idle(3);

        // Good frame.
        send_bytes(40'hA5_23_59_95_B5, 5, 10);
        idle(2);
        check("good_x", 32'(x_value_rm), 32'h123);
        check("good_y", 32'(y_value_rm), 32'h2AB);
        check("good_level", 32'(level_rm), 32'd2);
        check("good_link_up", {31'd0, link_up}, 32'd1);
        check("good_err_count", 32'(err_count), 32'd0);

        // Bad checksum.
        send_bytes(40'hA5_23_59_95_B4, 5, 10);
        idle(2);
        check("badchk_x", 32'(x_value_rm), 32'h123);
        check("badchk_err_count", 32'(err_count), 32'd1);

        // Gap abort after two bytes, then a good frame.
        send_bytes(40'hA5_23_00_00_00, 2, 10);
        idle(110);
        check("gap_err_count", 32'(err_count), 32'd2);
        send_bytes(encode(11'h7FF, 11'h001, 2'd3), 5, 10);
        idle(2);
        check("after_gap_x", 32'(x_value_rm), 32'h7FF);
        check("after_gap_y", 32'(y_value_rm), 32'h001);
        check("after_gap_level", 32'(level_rm), 32'd3);

        // Leading garbage, SYNC values used as payload.
        strobe(8'h00); idle(10);
        strobe(8'hFF); idle(10);
        send_bytes(40'hA5_A5_A5_A5_FF, 5, 10);
        f_at = cyc;
        idle(1);
        check("sync_data_x", 32'(x_value_rm), 32'h5A5);
        check("sync_data_level", 32'(level_rm), 32'd2);
        check("sync_data_err_count", 32'(err_count), 32'd2);

        // Link timeout, position held.
        idle(f_at + LINK - 1 - cyc);
        check("link_before_timeout", {31'd0, link_up}, 32'd1);
        idle(1);
        check("link_at_timeout", {31'd0, link_up}, 32'd0);
        check("link_timeout_x_held", 32'(x_value_rm), 32'h5A5);

        // Reset mid-frame.
        send_bytes(40'hA5_23_59_00_00, 3, 10);
        idle(1);
        do_reset(3);
        strobe(8'h95); idle(10);
        strobe(8'hB5); idle(3);
        check_outputs("mid_reset");
        check("mid_reset_link_up", {31'd0, link_up}, 32'd0);
        send_bytes(40'hA5_23_59_95_B5, 5, 10);
        idle(2);
        check("after_reset_x", 32'(x_value_rm), 32'h123);

        // Randomized traffic.
        for (int it = 0; it < 200; it++) begin
            int kind;
            logic [39:0] f;
            kind = $urandom_range(0, 9);
            f = encode(11'($urandom), 11'($urandom), 2'($urandom));
            if (kind < 6) begin
                send_bytes(f, 5, rand_gap());
            end else if (kind < 8) begin
                f[7:0] = f[7:0] ^ (8'd1 << $urandom_range(0, 7));
                send_bytes(f, 5, rand_gap());
            end else if (kind == 8) begin
                send_bytes(f, $urandom_range(1, 4), rand_gap());
            end else begin
                strobe(8'($urandom));
            end
            idle(rand_gap());
        end
        idle(GAP + 5);
        check_outputs("random_end");

        // err_count saturation.
        do_reset(2);
        idle(2);
        for (int i = 0; i < 260; i++) begin
            send_bytes(40'hA5_01_02_03_00, 5, 0);
        end
        idle(3);
        check("saturated_err_count", 32'(err_count), 32'hFF);

        idle(GAP + 5);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
